// File: rtl/imem_boot_loader.sv
// Boot loader: parses a framed byte stream (count, LE words, XOR checksum) into
// instruction SRAM writes and holds the CPU in reset until the image verifies.
module imem_boot_loader #(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned MAX_WORDS = 16384
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    input  logic              restart,
    output logic [3:0]        im_w_en,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err,
    output logic [15:0]       words_loaded
);

    localparam logic [ADDR_W-1:0] L_BASE = ADDR_W'(BASE_ADDR);

    typedef enum logic [2:0] {
        S_HDR_LO,
        S_HDR_HI,
        S_DATA,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    state_t            r_state,  w_state_nxt;
    logic [15:0]       r_count,  w_count_nxt;
    logic [1:0]        r_idx,    w_idx_nxt;
    logic [7:0]        r_chk,    w_chk_nxt;
    logic [3:0]        r_w_en,   w_w_en_nxt;
    logic [ADDR_W-1:0] r_addr,   w_addr_nxt;
    logic [31:0]       r_wdata,  w_wdata_nxt;
    logic [15:0]       r_words,  w_words_nxt;
    logic              r_hold,   w_hold_nxt;
    logic              r_done,   w_done_nxt;
    logic              r_err,    w_err_nxt;

    logic              w_ready;
    logic              w_accept;
    logic [15:0]       w_hdr_count;

    assign w_ready     = (r_state != S_DONE) && (r_state != S_ERR);
    assign w_accept    = rx_valid & w_ready;
    assign w_hdr_count = {rx_data, r_count[7:0]};

    // Next-state and next-output decode
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_idx_nxt   = r_idx;
        w_chk_nxt   = r_chk;
        w_w_en_nxt  = 4'b0000;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        w_words_nxt = r_words;
        w_hold_nxt  = r_hold;
        w_done_nxt  = r_done;
        w_err_nxt   = r_err;

        // Address moves on only once the write cycle has completed
        if (r_w_en != 4'b0000) begin
            w_addr_nxt = r_addr + ADDR_W'(4);
        end

        case (r_state)
            S_HDR_LO: begin
                if (w_accept) begin
                    w_count_nxt[7:0] = rx_data;
                    w_state_nxt      = S_HDR_HI;
                end
            end
            S_HDR_HI: begin
                if (w_accept) begin
                    w_count_nxt = w_hdr_count;
                    if (w_hdr_count == 16'd0) begin
                        w_state_nxt = S_CHK;
                    end else if (32'(w_hdr_count) > MAX_WORDS) begin
                        w_state_nxt = S_ERR;
                        w_err_nxt   = 1'b1;
                    end else begin
                        w_state_nxt = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_accept) begin
                    w_wdata_nxt[{r_idx, 3'b000} +: 8] = rx_data;
                    w_chk_nxt = r_chk ^ rx_data;
                    w_idx_nxt = r_idx + 2'd1;
                    if (r_idx == 2'd3) begin
                        w_w_en_nxt  = 4'b1111;
                        w_words_nxt = r_words + 16'd1;
                        if (r_words + 16'd1 == r_count) begin
                            w_state_nxt = S_CHK;
                        end
                    end
                end
            end
            S_CHK: begin
                if (w_accept) begin
                    if (rx_data == r_chk) begin
                        w_state_nxt = S_DONE;
                        w_done_nxt  = 1'b1;
                        w_hold_nxt  = 1'b0;
                    end else begin
                        w_state_nxt = S_ERR;
                        w_err_nxt   = 1'b1;
                    end
                end
            end
            S_DONE, S_ERR: begin
                if (restart) begin
                    w_state_nxt = S_HDR_LO;
                    w_count_nxt = 16'd0;
                    w_idx_nxt   = 2'd0;
                    w_chk_nxt   = 8'd0;
                    w_addr_nxt  = L_BASE;
                    w_wdata_nxt = 32'd0;
                    w_words_nxt = 16'd0;
                    w_hold_nxt  = 1'b1;
                    w_done_nxt  = 1'b0;
                    w_err_nxt   = 1'b0;
                end
            end
            default: begin
                w_state_nxt = S_HDR_LO;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_HDR_LO;
            r_count <= 16'd0;
            r_idx   <= 2'd0;
            r_chk   <= 8'd0;
            r_w_en  <= 4'b0000;
            r_addr  <= L_BASE;
            r_wdata <= 32'd0;
            r_words <= 16'd0;
            r_hold  <= 1'b1;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_idx   <= w_idx_nxt;
            r_chk   <= w_chk_nxt;
            r_w_en  <= w_w_en_nxt;
            r_addr  <= w_addr_nxt;
            r_wdata <= w_wdata_nxt;
            r_words <= w_words_nxt;
            r_hold  <= w_hold_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign rx_ready     = w_ready;
    assign im_w_en      = r_w_en;
    assign im_addr      = r_addr;
    assign im_wdata     = r_wdata;
    assign cpu_hold     = r_hold;
    assign load_done    = r_done;
    assign load_err     = r_err;
    assign words_loaded = r_words;

endmodule
